// File: rtl/sprite_blitter.sv
// sprite_blitter: streams a rectangular RGB565 sprite from ROM into the SRAM controller
// write port, holding each drawn pixel and skipping colour-keyed or off-screen texels.
module sprite_blitter #(
   parameter int unsigned HOLD_CYCLES = 4,
   parameter logic [15:0] TRANSPARENT = 16'hF81F,
   parameter int unsigned SCREEN_W    = 640,
   parameter int unsigned SCREEN_H    = 480
) (
   input  logic        sram_clk,
   input  logic        reset,
   input  logic        frame_clk,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [9:0]  cmd_x,
   input  logic [9:0]  cmd_y,
   input  logic [5:0]  cmd_w,
   input  logic [5:0]  cmd_h,
   input  logic [11:0] cmd_base,
   output logic [11:0] rom_addr,
   input  logic [15:0] rom_data,
   output logic [9:0]  program_x,
   output logic [9:0]  program_y,
   output logic [15:0] program_data,
   output logic        busy,
   output logic        done,
   output logic        overrun
);

   localparam int unsigned    HCW        = $clog2(HOLD_CYCLES);
   localparam logic [HCW-1:0] HOLD_LAST  = HCW'(HOLD_CYCLES - 1);
   localparam logic [10:0]    SCREEN_W_L = 11'(SCREEN_W);
   localparam logic [10:0]    SCREEN_H_L = 11'(SCREEN_H);
   localparam logic [9:0]     PARK_X     = 10'h3FF;
   localparam logic [9:0]     PARK_Y     = 10'h1FF;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_EVAL  = 2'd2,
      S_HOLD  = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [9:0]      x_q, x_d, y_q, y_d;
   logic [5:0]      w_q, w_d, h_q, h_d;
   logic [5:0]      col_q, col_d, row_q, row_d;
   logic [HCW-1:0]  hold_cnt_q, hold_cnt_d;
   logic [11:0]     rom_addr_q, rom_addr_d;
   logic [9:0]      prog_x_q, prog_x_d, prog_y_q, prog_y_d;
   logic [15:0]     prog_data_q, prog_data_d;
   logic            busy_q, busy_d, done_q, done_d, overrun_q, overrun_d;
   logic            cmd_ready_q, cmd_ready_d;
   logic            meta_q, meta_d, sync_q, sync_d, sync_dly_q, sync_dly_d;

   logic            swap_s, advance_s, opaque_s, last_col_s, last_px_s;
   logic [10:0]     px_s, py_s;

   // Next-state, datapath and output computation for the blit sequencer.
   always_comb begin
      state_d     = state_q;
      x_d         = x_q;
      y_d         = y_q;
      w_d         = w_q;
      h_d         = h_q;
      col_d       = col_q;
      row_d       = row_q;
      hold_cnt_d  = hold_cnt_q;
      rom_addr_d  = rom_addr_q;
      prog_x_d    = prog_x_q;
      prog_y_d    = prog_y_q;
      prog_data_d = prog_data_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      overrun_d   = 1'b0;
      cmd_ready_d = 1'b0;
      meta_d      = frame_clk;
      sync_d      = meta_q;
      sync_dly_d  = sync_q;
      advance_s   = 1'b0;

      swap_s     = sync_q & ~sync_dly_q;
      px_s       = {1'b0, x_q} + {5'd0, col_q};
      py_s       = {1'b0, y_q} + {5'd0, row_q};
      opaque_s   = (rom_data != TRANSPARENT) && (px_s < SCREEN_W_L) && (py_s < SCREEN_H_L);
      last_col_s = (col_q == (w_q - 6'd1));
      last_px_s  = last_col_s && (row_q == (h_q - 6'd1));

      case (state_q)
         S_IDLE: begin
            if (cmd_valid && cmd_ready_q) begin
               x_d        = cmd_x;
               y_d        = cmd_y;
               w_d        = cmd_w;
               h_d        = cmd_h;
               col_d      = 6'd0;
               row_d      = 6'd0;
               rom_addr_d = cmd_base;
               if ((cmd_w == 6'd0) || (cmd_h == 6'd0)) begin
                  done_d = 1'b1;
               end else begin
                  busy_d  = 1'b1;
                  state_d = S_FETCH;
               end
            end else begin
               cmd_ready_d = 1'b1;
            end
         end
         S_FETCH: begin
            state_d = S_EVAL;
         end
         S_EVAL: begin
            if (opaque_s) begin
               prog_x_d    = px_s[9:0];
               prog_y_d    = py_s[9:0];
               prog_data_d = rom_data;
               hold_cnt_d  = {HCW{1'b0}};
               state_d     = S_HOLD;
            end else begin
               advance_s = 1'b1;
            end
         end
         S_HOLD: begin
            if (hold_cnt_q == HOLD_LAST) begin
               advance_s = 1'b1;
            end else begin
               hold_cnt_d = hold_cnt_q + {{(HCW-1){1'b0}}, 1'b1};
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // The address only ever steps by one, so row-major traversal needs no multiplier.
      if (advance_s) begin
         if (last_px_s) begin
            done_d   = 1'b1;
            busy_d   = 1'b0;
            prog_x_d = PARK_X;
            prog_y_d = PARK_Y;
            state_d  = S_IDLE;
         end else begin
            rom_addr_d = rom_addr_q + 12'd1;
            state_d    = S_FETCH;
            if (last_col_s) begin
               col_d = 6'd0;
               row_d = row_q + 6'd1;
            end else begin
               col_d = col_q + 6'd1;
            end
         end
      end else begin
         hold_cnt_d = hold_cnt_d;
      end

      // A frame swap wins over everything in flight, including a same-cycle completion.
      if (swap_s) begin
         prog_x_d = PARK_X;
         prog_y_d = PARK_Y;
         if (state_q != S_IDLE) begin
            state_d     = S_IDLE;
            busy_d      = 1'b0;
            done_d      = 1'b0;
            overrun_d   = 1'b1;
            cmd_ready_d = 1'b0;
            hold_cnt_d  = {HCW{1'b0}};
            rom_addr_d  = rom_addr_q;
            prog_data_d = prog_data_q;
            col_d       = col_q;
            row_d       = row_q;
         end else begin
            overrun_d = 1'b0;
         end
      end else begin
         overrun_d = overrun_d;
      end
   end

   // State and output registers with asynchronous reset.
   always_ff @(posedge sram_clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         x_q         <= 10'd0;
         y_q         <= 10'd0;
         w_q         <= 6'd0;
         h_q         <= 6'd0;
         col_q       <= 6'd0;
         row_q       <= 6'd0;
         hold_cnt_q  <= {HCW{1'b0}};
         rom_addr_q  <= 12'd0;
         prog_x_q    <= PARK_X;
         prog_y_q    <= PARK_Y;
         prog_data_q <= 16'd0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         overrun_q   <= 1'b0;
         cmd_ready_q <= 1'b0;
         meta_q      <= 1'b0;
         sync_q      <= 1'b0;
         sync_dly_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         x_q         <= x_d;
         y_q         <= y_d;
         w_q         <= w_d;
         h_q         <= h_d;
         col_q       <= col_d;
         row_q       <= row_d;
         hold_cnt_q  <= hold_cnt_d;
         rom_addr_q  <= rom_addr_d;
         prog_x_q    <= prog_x_d;
         prog_y_q    <= prog_y_d;
         prog_data_q <= prog_data_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         overrun_q   <= overrun_d;
         cmd_ready_q <= cmd_ready_d;
         meta_q      <= meta_d;
         sync_q      <= sync_d;
         sync_dly_q  <= sync_dly_d;
      end
   end

   assign cmd_ready    = cmd_ready_q;
   assign rom_addr     = rom_addr_q;
   assign program_x    = prog_x_q;
   assign program_y    = prog_y_q;
   assign program_data = prog_data_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign overrun      = overrun_q;

endmodule

// File: tb/tb_sprite_blitter.sv
// tb_sprite_blitter: directed and randomized bench; a per-pixel reference model predicts the
// cycle-by-cycle trace of program_*, rom_addr and the handshake/status outputs.
module tb_sprite_blitter;

   localparam logic [15:0] TRANSP = 16'hF81F;
   localparam int          HOLD   = 4;
   localparam logic [9:0]  PARK_X = 10'h3FF;
   localparam logic [9:0]  PARK_Y = 10'h1FF;

   logic        sram_clk = 1'b0;
   logic        reset;
   logic        frame_clk;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [9:0]  cmd_x, cmd_y;
   logic [5:0]  cmd_w, cmd_h;
   logic [11:0] cmd_base;
   logic [11:0] rom_addr;
   logic [15:0] rom_data;
   logic [9:0]  program_x, program_y;
   logic [15:0] program_data;
   logic        busy, done, overrun;

   logic [15:0] rom [4096];
   logic [15:0] model_data;
   int          n_chk  = 0;
   int          n_pass = 0;
   int          bl;

   sprite_blitter dut (
      .sram_clk     (sram_clk),
      .reset        (reset),
      .frame_clk    (frame_clk),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_x        (cmd_x),
      .cmd_y        (cmd_y),
      .cmd_w        (cmd_w),
      .cmd_h        (cmd_h),
      .cmd_base     (cmd_base),
      .rom_addr     (rom_addr),
      .rom_data     (rom_data),
      .program_x    (program_x),
      .program_y    (program_y),
      .program_data (program_data),
      .busy         (busy),
      .done         (done),
      .overrun      (overrun)
   );

   always #5 sram_clk = ~sram_clk;

   // Synchronous sprite ROM: data follows the address by one cycle.
   always @(posedge sram_clk) rom_data <= rom[rom_addr];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
   endtask

   function automatic logic [63:0] pack(input logic rdy, input logic dn, input logic ov,
                                        input logic bz, input logic [9:0] x, input logic [9:0] y,
                                        input logic [15:0] d, input logic [11:0] a);
      return {12'd0, rdy, dn, ov, bz, x, y, d, a};
   endfunction

   function automatic logic [63:0] dut_vec();
      return pack(cmd_ready, done, overrun, busy, program_x, program_y, program_data, rom_addr);
   endfunction

   task automatic scramble();
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_x     = 10'($urandom);
      cmd_y     = 10'($urandom);
      cmd_w     = 6'($urandom);
      cmd_h     = 6'($urandom);
      cmd_base  = 12'($urandom);
   endtask

   // abort_at >= 0 raises frame_clk at that cycle offset and expects an overrun instead of done.
   task automatic run_cmd(input logic [9:0] x, input logic [9:0] y, input logic [5:0] w,
                          input logic [5:0] h, input logic [11:0] base, input int abort_at,
                          output int busy_n);
      logic [63:0] exp_q[$];
      logic [9:0]  cx, cy;
      logic [15:0] cd;
      logic [11:0] a;
      int          px, py, ovr_j;
      cx = PARK_X; cy = PARK_Y; cd = model_data; a = base;
      for (int r = 0; r < int'(h); r++) begin
         for (int c = 0; c < int'(w); c++) begin
            a  = 12'((int'(base) + r * int'(w) + c) % 4096);
            px = int'(x) + c;
            py = int'(y) + r;
            repeat (2) exp_q.push_back(pack(1'b0, 1'b0, 1'b0, 1'b1, cx, cy, cd, a));
            if (rom[a] != TRANSP && px < 640 && py < 480) begin
               cx = 10'(px); cy = 10'(py); cd = rom[a];
               repeat (HOLD) exp_q.push_back(pack(1'b0, 1'b0, 1'b0, 1'b1, cx, cy, cd, a));
            end
         end
      end

      @(negedge sram_clk);
      chk("ready", 64'(cmd_ready), 64'd1);
      cmd_x = x; cmd_y = y; cmd_w = w; cmd_h = h; cmd_base = base; cmd_valid = 1'b1;
      @(posedge sram_clk);
      #1;
      scramble();

      busy_n = 0;
      ovr_j  = -1;
      for (int j = 0; j < exp_q.size(); j++) begin
         @(negedge sram_clk);
         if (abort_at >= 0 && overrun === 1'b1) begin
            ovr_j = j;
            cmd_valid = 1'b0;
            break;
         end
         if (busy === 1'b1) busy_n++;
         chk("cycle", dut_vec(), exp_q[j]);
         if (j == abort_at) frame_clk = 1'b1;
         if (j == exp_q.size() - 1) cmd_valid = 1'b0;
         else scramble();
      end

      if (abort_at >= 0) begin
         chk("ovr_latency", 64'((ovr_j - abort_at == 3) || (ovr_j - abort_at == 4)), 64'd1);
         chk("abort_state", 64'({cmd_ready, done, overrun, busy, program_x, program_y}),
             64'({1'b0, 1'b0, 1'b1, 1'b0, PARK_X, PARK_Y}));
         @(negedge sram_clk);
         chk("ovr_pulse", 64'({done, overrun, busy}), 64'd0);
         frame_clk = 1'b0;
      end else begin
         @(negedge sram_clk);
         chk("done", dut_vec(), pack(1'b0, 1'b1, 1'b0, 1'b0, PARK_X, PARK_Y, cd, a));
         cmd_valid = 1'b0;
         @(negedge sram_clk);
         chk("idle", 64'({cmd_ready, done, busy}), 64'b100);
         chk("busy_len", 64'(busy_n), 64'(exp_q.size()));
         model_data = cd;
      end
   endtask

   initial begin
      for (int i = 0; i < 4096; i++)
         rom[i] = ($urandom_range(0, 3) == 0) ? TRANSP : 16'($urandom);
      reset = 1'b1; frame_clk = 1'b0; cmd_valid = 1'b0;
      cmd_x = 10'd0; cmd_y = 10'd0; cmd_w = 6'd0; cmd_h = 6'd0; cmd_base = 12'd0;
      model_data = 16'd0;

      repeat (2) @(negedge sram_clk);
      chk("reset_vals", dut_vec(), pack(1'b0, 1'b0, 1'b0, 1'b0, PARK_X, PARK_Y, 16'd0, 12'd0));
      reset = 1'b0;
      #1;
      chk("rdy_low_at_release", 64'(cmd_ready), 64'd0);
      @(negedge sram_clk);
      chk("rdy_after_release", 64'(cmd_ready), 64'd1);

      // 2x2 fully opaque sprite.
      rom[12'h100] = 16'h1111; rom[12'h101] = 16'h2222;
      rom[12'h102] = 16'h3333; rom[12'h103] = 16'h4444;
      run_cmd(10'd10, 10'd20, 6'd2, 6'd2, 12'h100, -1, bl);
      chk("busy_2x2", 64'(bl), 64'd24);
      chk("rom_end", 64'(rom_addr), 64'h103);

      // Transparent second texel.
      rom[12'h200] = 16'h1111; rom[12'h201] = TRANSP;
      rom[12'h202] = 16'h3333; rom[12'h203] = 16'h4444;
      run_cmd(10'd10, 10'd20, 6'd2, 6'd2, 12'h200, -1, bl);
      chk("busy_transp", 64'(bl), 64'd20);

      // Right-edge clipping.
      rom[12'h300] = 16'h0A0A; rom[12'h301] = 16'h0B0B;
      run_cmd(10'd639, 10'd100, 6'd2, 6'd1, 12'h300, -1, bl);
      chk("busy_clip", 64'(bl), 64'd8);

      // Empty commands and an address wrap.
      run_cmd(10'd5, 10'd5, 6'd0, 6'd3, 12'h456, -1, bl);
      run_cmd(10'd5, 10'd5, 6'd4, 6'd0, 12'h789, -1, bl);
      run_cmd(10'd50, 10'd60, 6'd3, 6'd1, 12'hFFE, -1, bl);

      for (int k = 0; k < 25; k++) begin
         run_cmd(($urandom_range(0, 1) == 1) ? 10'($urandom_range(600, 639)) : 10'($urandom),
                 ($urandom_range(0, 1) == 1) ? 10'($urandom_range(440, 479)) : 10'($urandom),
                 6'($urandom_range(0, 7)), 6'($urandom_range(0, 7)), 12'($urandom), -1, bl);
      end

      // Frame swap during a 16x16 sprite.
      run_cmd(10'd100, 10'd100, 6'd16, 6'd16, 12'h500, 20, bl);
      repeat (4) @(negedge sram_clk);
      chk("post_abort_quiet", 64'({cmd_ready, done, overrun, busy}), 64'b1000);

      // Reset landing in the middle of a HOLD.
      rom[12'h040] = 16'h5555;
      cmd_x = 10'd5; cmd_y = 10'd5; cmd_w = 6'd2; cmd_h = 6'd2; cmd_base = 12'h040;
      cmd_valid = 1'b1;
      @(posedge sram_clk);
      #1;
      cmd_valid = 1'b0;
      repeat (4) @(negedge sram_clk);
      chk("pre_reset_hold", 64'({program_x, program_y, program_data}),
          64'({10'd5, 10'd5, 16'h5555}));
      reset = 1'b1;
      #1;
      chk("mid_reset_vals", dut_vec(), pack(1'b0, 1'b0, 1'b0, 1'b0, PARK_X, PARK_Y, 16'd0, 12'd0));
      @(negedge sram_clk);
      reset = 1'b0;
      #1;
      chk("rdy_low_release2", 64'(cmd_ready), 64'd0);
      @(negedge sram_clk);
      chk("rdy_after_release2", 64'(cmd_ready), 64'd1);
      model_data = 16'd0;
      run_cmd(10'd10, 10'd20, 6'd2, 6'd2, 12'h100, -1, bl);
      chk("busy_after_reset", 64'(bl), 64'd24);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
